operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 131 +++++++++++++
 tb/tb_operand_fetch.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch: decode-stage operand fetch for an RV32 pipeline.
// It takes one instruction at a time from upstream and reads rs1/rs2 from a
// synchronous-read register file. It replays the read if writeback collides
// with the read edge. It forwards a same-cycle writeback into the operand
// capture, and keeps a held output coherent with later writebacks.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          upstream handshake, in_instr/in_pc payload
//   rf_ra1/rf_ra2              register-file read addresses (zero-extended rs)
//   rf_dr1/rf_dr2              register-file registered read data
//   wb_we/wb_wa/wb_dw          writeback port to the register file (snooped)
//   flush                      synchronous kill of the in-flight instruction
//   out_valid/out_ready        downstream handshake
//   out_instr/out_pc           the fetched instruction and its PC
//   out_rs1_val/out_rs2_val    resolved operands
//
// state | meaning
// IDLE  | waiting for an instruction, in_ready=1
// ISSUE | read addresses presented; replays while writeback collides
// READ  | register file data valid; captured (or forwarded) at the edge
// OUT   | operands presented downstream, out_valid=1
module operand_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [31:0] rf_ra1,
    output logic [31:0] rf_ra2,
    input  logic [31:0] rf_dr1,
    input  logic [31:0] rf_dr2,
    input  logic        wb_we,
    input  logic [31:0] wb_wa,
    input  logic [31:0] wb_dw,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_rs1_val,
    output logic [31:0] out_rs2_val
);

    typedef enum logic [1:0] {IDLE, ISSUE, READ, OUT} state_t;

    state_t      state_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] ra1_q;
    logic [31:0] ra2_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;

    logic        rs1_zero;
    logic        rs2_zero;
    logic        collision;
    logic        wb_hit1;
    logic        wb_hit2;

    assign rs1_zero  = (ra1_q == 32'd0);
    assign rs2_zero  = (ra2_q == 32'd0);

    // Full-width compare with x0 included: the register file suppresses both
    // reads on any write to a presented address, even a write to x0.
    assign collision = wb_we && ((wb_wa == ra1_q) || (wb_wa == ra2_q));

    // Forwarding never applies to x0; that operand is always zero.
    assign wb_hit1   = wb_we && (wb_wa == ra1_q) && !rs1_zero;
    assign wb_hit2   = wb_we && (wb_wa == ra2_q) && !rs2_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            instr_q <= 32'd0;
            pc_q    <= 32'd0;
            ra1_q   <= 32'd0;
            ra2_q   <= 32'd0;
            op1_q   <= 32'd0;
            op2_q   <= 32'd0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        instr_q <= in_instr;
                        pc_q    <= in_pc;
                        ra1_q   <= {27'd0, in_instr[19:15]};
                        ra2_q   <= {27'd0, in_instr[24:20]};
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!collision) begin
                        state_q <= READ;
                    end
                end
                READ: begin
                    op1_q   <= wb_hit1 ? wb_dw : rf_dr1;
                    op2_q   <= wb_hit2 ? wb_dw : rf_dr2;
                    state_q <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end else begin
                        // A held result must track writes to its sources.
                        if (wb_hit1) op1_q <= wb_dw;
                        if (wb_hit2) op2_q <= wb_dw;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // in_ready is gated by rst_n so it reads 0 while reset is held and 1 in
    // the first cycle after release.
    assign in_ready    = rst_n && (state_q == IDLE);
    assign out_valid   = (state_q == OUT);
    assign out_instr   = instr_q;
    assign out_pc      = pc_q;
    assign rf_ra1      = ra1_q;
    assign rf_ra2      = ra2_q;
    // x0 operands are zero whatever the register file returned.
    assign out_rs1_val = rs1_zero ? 32'd0 : op1_q;
    assign out_rs2_val = rs2_zero ? 32'd0 : op2_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] rf_ra1;
    logic [31:0] rf_ra2;
    logic [31:0] rf_dr1;
    logic [31:0] rf_dr2;
    logic        wb_we;
    logic [31:0] wb_wa;
    logic [31:0] wb_dw;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;

    operand_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .rf_ra1     (rf_ra1),
        .rf_ra2     (rf_ra2),
        .rf_dr1     (rf_dr1),
        .rf_dr2     (rf_dr2),
        .wb_we      (wb_we),
        .wb_wa      (wb_wa),
        .wb_dw      (wb_dw),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_rs1_val(out_rs1_val),
        .out_rs2_val(out_rs2_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: synchronous write, registered read, both reads
    // suppressed on an edge where the write hits a presented address.
    // x0 is stored like any register so the DUT must do its own zeroing.
    logic [31:0] regs [0:31];
    always @(posedge clk) begin
        if (wb_we && wb_wa < 32) regs[wb_wa[4:0]] <= wb_dw;
        if (!(wb_we && (wb_wa == rf_ra1 || wb_wa == rf_ra2))) begin
            rf_dr1 <= regs[rf_ra1[4:0]];
            rf_dr2 <= regs[rf_ra2[4:0]];
        end
    end

    typedef struct {
        logic [127:0] data;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction

    function automatic logic [127:0] obs();
        return {out_instr, out_pc, out_rs1_val, out_rs2_val};
    endfunction

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_wa = a; wb_dw = d;
        @(negedge clk);
        wb_we = 1'b0;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(inout int lat);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else begin e.data = '0; e.lat = -1; end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b00) begin
            failures++;
            $display("FAIL reset_handshake got in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
        end
        checks++;
        if ({obs(), rf_ra1, rf_ra2} !== 192'd0) begin
            failures++;
            $display("FAIL reset_outputs got %h want 0", {obs(), rf_ra1, rf_ra2});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_t e;
        int lat;
        logic [31:0] ins;
        wb_write(32'd5, 32'h11);
        wb_write(32'd6, 32'h22);
        ins = mk_r(5'd7, 5'd5, 5'd6);
        sb_q.push_back('{{ins, 32'h100, 32'h11, 32'h22}, 3});
        send(ins, 32'h100);
        lat = 1;
        checks++;
        if ({rf_ra1, rf_ra2} !== {32'd5, 32'd6}) begin
            failures++;
            $display("FAIL basic_ra got %h %h want 5 6", rf_ra1, rf_ra2);
        end
        wait_out(lat);
        pop_exp(e);
        checks++;
        if (lat !== e.lat) begin
            failures++;
            $display("FAIL basic_latency got %0d want %0d", lat, e.lat);
        end
        checks++;
        if (obs() !== e.data) begin
            failures++;
            $display("FAIL basic_data got %h want %h", obs(), e.data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL basic_release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_collision();
        exp_t e;
        int lat;
        logic [31:0] ins;
        ins = mk_r(5'd7, 5'd5, 5'd6);
        sb_q.push_back('{{ins, 32'h104, 32'hAA, 32'h22}, 4});
        send(ins, 32'h104);
        lat = 1;
        wb_we = 1'b1; wb_wa = 32'd5; wb_dw = 32'hAA;
        @(negedge clk);
        lat = 2;
        wb_we = 1'b0;
        wait_out(lat);
        pop_exp(e);
        checks++;
        if (lat !== e.lat) begin
            failures++;
            $display("FAIL collision_latency got %0d want %0d", lat, e.lat);
        end
        checks++;
        if (obs() !== e.data) begin
            failures++;
            $display("FAIL collision_data got %h want %h", obs(), e.data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_read_forward();
        exp_t e;
        int lat;
        logic [31:0] ins;
        ins = mk_r(5'd8, 5'd5, 5'd6);
        sb_q.push_back('{{ins, 32'h108, 32'hAA, 32'h55}, 3});
        send(ins, 32'h108);
        @(negedge clk);
        lat = 2;
        wb_we = 1'b1; wb_wa = 32'd6; wb_dw = 32'h55;
        @(negedge clk);
        lat = 3;
        wb_we = 1'b0;
        wait_out(lat);
        pop_exp(e);
        checks++;
        if (lat !== e.lat) begin
            failures++;
            $display("FAIL fwd_latency got %0d want %0d", lat, e.lat);
        end
        checks++;
        if (obs() !== e.data) begin
            failures++;
            $display("FAIL fwd_data got %h want %h", obs(), e.data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_out_hold();
        exp_t e;
        int lat;
        logic [31:0] ins;
        ins = mk_r(5'd9, 5'd5, 5'd6);
        sb_q.push_back('{{ins, 32'h10C, 32'h99, 32'h55}, 3});
        send(ins, 32'h10C);
        lat = 1;
        wait_out(lat);
        pop_exp(e);
        checks++;
        if (out_rs1_val !== 32'hAA) begin
            failures++;
            $display("FAIL hold_before_write got %h want aa", out_rs1_val);
        end
        wb_we = 1'b1; wb_wa = 32'd5; wb_dw = 32'h99;
        @(negedge clk);
        wb_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!out_valid || obs() !== e.data) begin
                failures++;
                $display("FAIL hold_cycle%0d got v=%b %h want v=1 %h", i, out_valid, obs(), e.data);
            end
            if (i < 3) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_release got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_x0();
        exp_t e;
        int lat;
        logic [31:0] ins;
        ins = mk_r(5'd10, 5'd0, 5'd6);
        sb_q.push_back('{{ins, 32'h110, 32'h0, 32'h55}, 4});
        send(ins, 32'h110);
        wb_we = 1'b1; wb_wa = 32'd0; wb_dw = 32'hFF;
        @(negedge clk);
        wb_we = 1'b0;
        @(negedge clk);
        wb_we = 1'b1; wb_wa = 32'd0; wb_dw = 32'hEE;
        @(negedge clk);
        lat = 4;
        wb_we = 1'b0;
        wait_out(lat);
        pop_exp(e);
        checks++;
        if (lat !== e.lat) begin
            failures++;
            $display("FAIL x0_latency got %0d want %0d", lat, e.lat);
        end
        checks++;
        if (obs() !== e.data) begin
            failures++;
            $display("FAIL x0_data got %h want %h", obs(), e.data);
        end
        wb_we = 1'b1; wb_wa = 32'd0; wb_dw = 32'h77;
        @(negedge clk);
        wb_we = 1'b0;
        checks++;
        if (out_rs1_val !== 32'h0) begin
            failures++;
            $display("FAIL x0_hold got %h want 0", out_rs1_val);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int nacc, nout;
        int t_out [2];
        logic [31:0] ia, ib;
        ia = mk_r(5'd1, 5'd5, 5'd6);
        ib = mk_r(5'd2, 5'd6, 5'd5);
        sb_q.push_back('{{ia, 32'h200, 32'h99, 32'h55}, 0});
        sb_q.push_back('{{ib, 32'h204, 32'h55, 32'h99}, 0});
        nacc = 0; nout = 0; t_out[0] = 0; t_out[1] = 0;
        in_valid = 1'b1; in_instr = ia; in_pc = 32'h200; out_ready = 1'b1;
        for (int i = 0; i < 30 && nout < 2; i++) begin
            if (out_valid) begin
                pop_exp(e);
                checks++;
                if (obs() !== e.data) begin
                    failures++;
                    $display("FAIL b2b_data%0d got %h want %h", nout, obs(), e.data);
                end
                t_out[nout] = cyc;
                nout++;
            end
            if (in_valid && in_ready) nacc++;
            @(negedge clk);
            if (nacc == 1) begin
                in_instr = ib; in_pc = 32'h204;
            end else if (nacc >= 2) begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (nout !== 2 || (t_out[1] - t_out[0]) !== 4) begin
            failures++;
            $display("FAIL b2b_spacing got outs=%0d gap=%0d want 2 4", nout, t_out[1] - t_out[0]);
        end
    endtask

    task automatic test_flush();
        bit seen;
        send(mk_r(5'd11, 5'd5, 5'd6), 32'h300);
        @(negedge clk);
        flush = 1'b1;
        wb_we = 1'b1; wb_wa = 32'd6; wb_dw = 32'h1234;
        @(negedge clk);
        flush = 1'b0;
        wb_we = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL flush_read got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        in_valid = 1'b1; in_instr = mk_r(5'd12, 5'd5, 5'd6); in_pc = 32'h304;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_accept got in_ready=%b want 1", in_ready);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) seen = 1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_output got out_valid seen=%b want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        send(mk_r(5'd13, 5'd5, 5'd6), 32'h400);
        lat = 1;
        wait_out(lat);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_reach_out got out_valid=%b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, obs(), rf_ra1, rf_ra2} !== 194'd0) begin
            failures++;
            $display("FAIL rstmid_async got v=%b r=%b %h want all 0", out_valid, in_ready, obs());
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL rstmid_after got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) seen = 1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_no_output got out_valid seen=%b want 0", seen);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        rf_dr1 = 32'd0; rf_dr2 = 32'd0;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
        wb_we = 1'b0; wb_wa = 32'd0; wb_dw = 32'd0;
        flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_collision();
        test_read_forward();
        test_out_hold();
        test_x0();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
